// File: rtl/jk_seq_ctrl.sv
// Command sequencer that drives per-bit J/K inputs of a JK-flop register bank.
// Accepts one command at a time, steps it in EXEC, then pulses done.
module jk_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             abort,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpClear  = 3'd1;
  localparam logic [2:0] OpSet    = 3'd2;
  localparam logic [2:0] OpLoad   = 3'd3;
  localparam logic [2:0] OpToggle = 3'd4;
  localparam logic [2:0] OpCntUp  = 3'd5;
  localparam logic [2:0] OpCntDn  = 3'd6;
  localparam logic [2:0] OpRotate = 3'd7;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic [WIDTH-1:0] t_up, t_dn, rot;
  logic             up_acc, dn_acc;
  logic             multi_step;

  // Toggle masks for binary count: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    t_up   = '0;
    t_dn   = '0;
    up_acc = 1'b1;
    dn_acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_up[i] = up_acc;
      t_dn[i] = dn_acc;
      up_acc  = up_acc & q_q[i];
      dn_acc  = dn_acc & ~q_q[i];
    end
  end

  assign rot        = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign multi_step = (op_q == OpCntUp) || (op_q == OpCntDn) || (op_q == OpRotate);

  always_comb begin
    j_o = '0;
    k_o = '0;
    if (state_q == StExec && !abort) begin
      unique case (op_q)
        OpNop: begin
          j_o = '0;
          k_o = '0;
        end
        OpClear: begin
          j_o = '0;
          k_o = '1;
        end
        OpSet: begin
          j_o = '1;
          k_o = '0;
        end
        OpLoad: begin
          j_o = data_q;
          k_o = ~data_q;
        end
        OpToggle: begin
          j_o = data_q;
          k_o = data_q;
        end
        OpCntUp: begin
          if (cnt_q != '0) begin
            j_o = t_up;
            k_o = t_up;
          end
        end
        OpCntDn: begin
          if (cnt_q != '0) begin
            j_o = t_dn;
            k_o = t_dn;
          end
        end
        OpRotate: begin
          if (cnt_q != '0) begin
            j_o = rot;
            k_o = ~rot;
          end
        end
        default: begin
          j_o = '0;
          k_o = '0;
        end
      endcase
    end
  end

  // JK cell: set where J&~Q, keep where ~K&Q; covers hold/clear/set/toggle.
  assign q_d = (j_o & ~q_q) | (~k_o & q_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          cnt_d   = cmd_cnt;
          state_d = StExec;
        end
      end
      StExec: begin
        if (abort || !multi_step || cnt_q <= CNT_W'(1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      data_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign cmd_ready = rst_n && (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign q         = q_q;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Randomized and directed bench for jk_seq_ctrl against a cycle-level behavioural model.
module tb_jk_seq_ctrl;

  localparam int W = 4;
  localparam int C = 4;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [C-1:0] cmd_cnt;
  logic         abort;
  logic [W-1:0] j_o;
  logic [W-1:0] k_o;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  jk_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_cnt   (cmd_cnt),
    .abort     (abort),
    .j_o       (j_o),
    .k_o       (k_o),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 stepping, 2 completion cycle; q tracked as a plain number.
  logic [W-1:0] m_q, nq, ej, ek, m_data;
  logic [2:0]   m_op;
  int           m_phase, nphase, m_rem;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_q", 32'(q), 32'(0));
      chk("rst_j", 32'(j_o), 32'(0));
      chk("rst_k", 32'(k_o), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_ready", 32'(cmd_ready), 32'(0));
      m_q     = '0;
      m_phase = 0;
      m_rem   = 0;
    end else begin
      ej     = '0;
      ek     = '0;
      nq     = m_q;
      nphase = m_phase;
      if (m_phase == 0) begin
        if (cmd_valid) begin
          m_op   = cmd_op;
          m_data = cmd_data;
          m_rem  = int'(cmd_cnt);
          nphase = 1;
        end
      end else if (m_phase == 1) begin
        if (abort) begin
          nphase = 2;
        end else if (m_op < 3'd5) begin
          case (m_op)
            3'd1: begin nq = '0; ek = '1; end
            3'd2: begin nq = '1; ej = '1; end
            3'd3: begin nq = m_data; ej = m_data; ek = ~m_data; end
            3'd4: begin nq = m_q ^ m_data; ej = m_data; ek = m_data; end
            default: ;
          endcase
          nphase = 2;
        end else if (m_rem == 0) begin
          nphase = 2;
        end else begin
          case (m_op)
            3'd5: begin nq = m_q + 1'b1; ej = m_q ^ nq; ek = ej; end
            3'd6: begin nq = m_q - 1'b1; ej = m_q ^ nq; ek = ej; end
            default: begin nq = {m_q[W-2:0], m_q[W-1]}; ej = nq; ek = ~nq; end
          endcase
          m_rem--;
          if (m_rem == 0) nphase = 2;
        end
      end else begin
        nphase = 0;
      end
      chk("q", 32'(q), 32'(m_q));
      chk("j_o", 32'(j_o), 32'(ej));
      chk("k_o", 32'(k_o), 32'(ek));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 2));
      m_q     = nq;
      m_phase = nphase;
    end
  end

  // Returns #1 after the accepting edge, i.e. inside the first EXEC cycle.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] data, input logic [C-1:0] cnt);
    logic acc;
    acc       = 1'b0;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
    end
    #1 cmd_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    logic rdy;
    rdy = 1'b0;
    for (int i = 0; i < 40 && !rdy; i++) begin
      @(negedge clk);
      rdy = cmd_ready;
    end
    if (!rdy) chk("idle_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    issue(3'd3, v, '0);
    wait_idle();
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_cnt   = '0;
    abort     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'(1));
    @(posedge clk);
    #1;

    // LOAD latency and drive values
    issue(3'd3, 4'b1010, '0);
    #1;
    chk("load_j", 32'(j_o), 32'(4'b1010));
    chk("load_k", 32'(k_o), 32'(4'b0101));
    @(posedge clk); #1;
    chk("load_q", 32'(q), 32'(4'b1010));
    chk("load_done", 32'(done), 32'(1));
    @(posedge clk); #1;
    chk("load_ready", 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;

    // COUNT_UP wrap
    load(4'b1110);
    issue(3'd5, '0, 4'd3);
    @(posedge clk); #1;
    chk("up_s1", 32'(q), 32'(4'b1111));
    @(posedge clk); #1;
    chk("up_s2", 32'(q), 32'(4'b0000));
    chk("up_nodone", 32'(done), 32'(0));
    @(posedge clk); #1;
    chk("up_s3", 32'(q), 32'(4'b0001));
    chk("up_done", 32'(done), 32'(1));
    wait_idle();

    // COUNT_DN wrap then TOGGLE
    load(4'b0000);
    issue(3'd6, '0, 4'd1);
    wait_idle();
    chk("dn_wrap", 32'(q), 32'(4'b1111));
    issue(3'd4, 4'b0101, '0);
    wait_idle();
    chk("toggle", 32'(q), 32'(4'b1010));

    // ROTATE and zero-count
    load(4'b1001);
    issue(3'd7, '0, 4'd2);
    @(posedge clk); #1;
    chk("rot_s1", 32'(q), 32'(4'b0011));
    @(posedge clk); #1;
    chk("rot_s2", 32'(q), 32'(4'b0110));
    wait_idle();
    issue(3'd7, '0, 4'd0);
    @(posedge clk); #1;
    chk("rot0_q", 32'(q), 32'(4'b0110));
    chk("rot0_done", 32'(done), 32'(1));
    wait_idle();

    // Abort in third step with a competing command held high
    load(4'b0000);
    issue(3'd5, '0, 4'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort     = 1'b1;
    cmd_op    = 3'd3;
    cmd_data  = 4'b1111;
    cmd_valid = 1'b1;
    #1;
    chk("abort_j", 32'(j_o), 32'(0));
    chk("abort_k", 32'(k_o), 32'(0));
    @(posedge clk); #1;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("abort_done", 32'(done), 32'(1));
    chk("abort_q", 32'(q), 32'(4'b0010));
    wait_idle();
    chk("abort_q_idle", 32'(q), 32'(4'b0010));

    // Reset in the middle of a count
    issue(3'd5, '0, 4'd5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_q", 32'(q), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_data  = W'($urandom_range(0, 15));
      cmd_cnt   = C'($urandom_range(0, 6));
      abort     = ($urandom_range(0, 9) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    rst_n     = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
